// File: rtl/dm_mmio_responder_if.sv
// Data-memory port between the single-cycle core and its data-side responder.
// The core drives address, store data and store enable; the responder returns
// combinational load data in the same cycle.
interface dm_mmio_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata
  );
endinterface

// File: rtl/dm_mmio_responder.sv
// Data-side responder for the single-cycle core.
// Decodes the core's data port into a word-addressed RAM (0x000-0x0FF) and a
// peripheral window at 0x100: GPIO out, synchronised GPIO in, and a 32-bit
// compare timer with sticky match/error status and an interrupt.
// Loads are combinational; every state change happens on the rising edge.
module dm_mmio_responder #(
  parameter int RAM_DEPTH = 64,
  parameter int GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  dm_mmio_responder_if.slave bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  // Word-index width; guarded so a degenerate depth still yields a legal vector.
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [7:0] RAM_DEPTH_B = 8'(RAM_DEPTH);

  // Register offsets within the peripheral window, in words (addr[7:2]).
  localparam logic [5:0] OFS_GPIO_OUT = 6'd0;
  localparam logic [5:0] OFS_GPIO_IN  = 6'd1;
  localparam logic [5:0] OFS_CTRL     = 6'd2;
  localparam logic [5:0] OFS_CNT      = 6'd3;
  localparam logic [5:0] OFS_CMP      = 6'd4;
  localparam logic [5:0] OFS_STAT     = 6'd5;

  // CTRL bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQ_EN = 2;

  // Storage
  logic [31:0]       ram_reg [RAM_DEPTH];
  logic [GPIO_W-1:0] gpio_out_reg;
  logic [GPIO_W-1:0] gpio_sync1_reg;
  logic [GPIO_W-1:0] gpio_sync2_reg;
  logic [2:0]        ctrl_reg;
  logic [31:0]       cnt_reg;
  logic [31:0]       cmp_reg;
  logic              stat_match_reg;
  logic              stat_err_reg;

  // Next-state values for the timer and status
  logic [31:0] cnt_next;
  logic        match_next;
  logic        err_next;
  logic        match_now;

  // Decode results
  logic          hi_zero;
  logic          ram_hit;
  logic          reg_hit;
  logic [5:0]    sel;
  logic [AW-1:0] ram_idx;
  logic          wr_ram;
  logic          wr_gpio;
  logic          wr_ctrl;
  logic          wr_cnt;
  logic          wr_cmp;
  logic          wr_stat;
  logic          wr_unmapped;

  // Byte-lane bits are deliberately ignored: every access is a full word.
  logic unused_lane_bits;
  assign unused_lane_bits = &{1'b0, bus.addr[1:0]};

  // Address decode: RAM below 0x100 (up to RAM_DEPTH words), registers at 0x100-0x114.
  always_comb begin
    hi_zero     = (bus.addr[31:9] == 23'd0);
    sel         = bus.addr[7:2];
    ram_idx     = bus.addr[AW+1:2];
    ram_hit     = hi_zero && !bus.addr[8] && ({2'b00, bus.addr[7:2]} < RAM_DEPTH_B);
    reg_hit     = hi_zero && bus.addr[8] && (bus.addr[7:2] <= OFS_STAT);
    wr_ram      = bus.we && ram_hit;
    wr_gpio     = bus.we && reg_hit && (sel == OFS_GPIO_OUT);
    wr_ctrl     = bus.we && reg_hit && (sel == OFS_CTRL);
    wr_cnt      = bus.we && reg_hit && (sel == OFS_CNT);
    wr_cmp      = bus.we && reg_hit && (sel == OFS_CMP);
    wr_stat     = bus.we && reg_hit && (sel == OFS_STAT);
    wr_unmapped = bus.we && !ram_hit && !reg_hit;
  end

  // Combinational load mux; unmapped and write-only-ignored lanes read zero.
  always_comb begin
    bus.rdata = 32'd0;
    if (ram_hit) begin
      bus.rdata = ram_reg[ram_idx];
    end else if (reg_hit) begin
      case (sel)
        OFS_GPIO_OUT: bus.rdata = 32'(gpio_out_reg);
        OFS_GPIO_IN:  bus.rdata = 32'(gpio_sync2_reg);
        OFS_CTRL:     bus.rdata = {29'd0, ctrl_reg};
        OFS_CNT:      bus.rdata = cnt_reg;
        OFS_CMP:      bus.rdata = cmp_reg;
        OFS_STAT:     bus.rdata = {30'd0, stat_err_reg, stat_match_reg};
        default:      bus.rdata = 32'd0;
      endcase
    end
  end

  // Timer and status next state. Priorities: a software CNT write beats
  // increment/reload, a fresh match beats a W1C clear, and the compare always
  // uses the pre-edge CMP so a CMP write only matters from the next cycle.
  always_comb begin
    match_now = ctrl_reg[CTRL_EN] && (cnt_reg == cmp_reg);

    cnt_next = cnt_reg;
    if (wr_cnt) begin
      cnt_next = bus.wdata;
    end else if (ctrl_reg[CTRL_EN]) begin
      if (match_now && ctrl_reg[CTRL_RELOAD]) begin
        cnt_next = 32'd0;
      end else begin
        cnt_next = cnt_reg + 32'd1;
      end
    end

    match_next = stat_match_reg;
    if (match_now) begin
      match_next = 1'b1;
    end else if (wr_stat && bus.wdata[0]) begin
      match_next = 1'b0;
    end

    err_next = stat_err_reg;
    if (wr_unmapped) begin
      err_next = 1'b1;
    end else if (wr_stat && bus.wdata[1]) begin
      err_next = 1'b0;
    end
  end

  // RAM array: cleared on reset so loads after reset are deterministic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        ram_reg[i] <= 32'd0;
      end
    end else if (wr_ram) begin
      ram_reg[ram_idx] <= bus.wdata;
    end
  end

  // GPIO output register and two-flop synchroniser for the external inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out_reg   <= '0;
      gpio_sync1_reg <= '0;
      gpio_sync2_reg <= '0;
    end else begin
      gpio_sync1_reg <= gpio_in;
      gpio_sync2_reg <= gpio_sync1_reg;
      if (wr_gpio) begin
        gpio_out_reg <= bus.wdata[GPIO_W-1:0];
      end
    end
  end

  // Timer control, count, compare and sticky status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_reg       <= 3'd0;
      cnt_reg        <= 32'd0;
      cmp_reg        <= 32'd0;
      stat_match_reg <= 1'b0;
      stat_err_reg   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_reg <= bus.wdata[2:0];
      end
      if (wr_cmp) begin
        cmp_reg <= bus.wdata;
      end
      cnt_reg        <= cnt_next;
      stat_match_reg <= match_next;
      stat_err_reg   <= err_next;
    end
  end

  // Outputs come straight from registers so they cannot glitch with addr.
  assign gpio_out  = gpio_out_reg;
  assign timer_irq = stat_match_reg && ctrl_reg[CTRL_IRQ_EN];

endmodule

// File: doc/dm_mmio_responder.md
# dm_mmio_responder

Data-side responder for the single-cycle core's data-memory port: it decodes the core's address, write data and write enable into a word-addressed RAM and a small memory-mapped peripheral window. The window holds a GPIO output register, a synchronised GPIO input and a 32-bit compare timer with interrupt. It replaces the plain data memory behind the core. Reads are combinational so the core completes loads in one cycle; all state changes occur on the rising clock edge.

## Interface
- RAM_DEPTH, 64: RAM words. Must be a power of two, with RAM_DEPTH*4 ≤ 0x100.
- GPIO_W, 16: GPIO output/input width. Must be ≤ 32.

- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- addr  input  32  byte address from the core's ALU result
- wdata  input  32  store data from the core's register file port 2
- we  input  1  store enable from the core's control unit
- rdata  output  32  combinational load data
- gpio_in  input  GPIO_W  external inputs, asynchronous to clk
- gpio_out  output  GPIO_W  GPIO_OUT register
- timer_irq  output  1  STAT.match AND CTRL.irq_en

## Operation
Address decode:
- `addr[1:0]` is ignored; all accesses are full-word.
- `addr[31:9]` must be zero for any region to match.

Address map:
- 0x000–0x0FF: RAM. Word index is `addr[log2(RAM_DEPTH)+1:2]`. Addresses between RAM_DEPTH*4 and 0xFF are unmapped.
- 0x100 GPIO_OUT, RW. Low GPIO_W bits are stored; upper bits read 0.
- 0x104 GPIO_IN, RO. Returns the 2-flop-synchronised gpio_in, zero-extended.
- 0x108 CTRL, RW:
  - bit0 enable
  - bit1 auto_reload
  - bit2 irq_en
  - other bits read 0
- 0x10C CNT, RW: 32-bit counter.
- 0x110 CMP, RW: 32-bit compare value.
- 0x114 STAT:
  - bit0 match, sticky
  - bit1 unmapped-access error, sticky
  - writing 1 to a bit clears it (W1C); writing 0 has no effect
- Everything else, including 0x118–0x1FF, is unmapped:
  - reads return 0x00000000
  - writes change no state except setting STAT.err
  - reads do not set STAT.err

Timer, evaluated at each rising edge with enable=1:
- If CNT==CMP: set STAT.match, and CNT←0 if auto_reload, else CNT←CNT+1, wrapping 0xFFFFFFFF→0.
- Otherwise: CNT←CNT+1.
- With enable=0, CNT holds and no match is detected.

Simultaneous events at one edge:
- A software write to CNT overrides both increment and reload.
- A match set overrides a W1C clear of STAT.match.
- A write to CMP takes effect next cycle; the current-cycle compare uses the old CMP.

## Timing
- Reset values (asynchronous, immediate on rst low):
  - all RAM words, GPIO_OUT, CTRL, CNT, CMP, STAT and sync flops = 0
  - gpio_out=0, timer_irq=0
  - rdata = decode of the current addr over the reset state
- Reset asserted mid-count clears everything at once. Counting resumes only after CTRL is rewritten.
- Write latency: state updates at the edge where we=1. A read of the same address in the following cycle returns the new value.
- A read in the same cycle as a write returns the pre-edge value (read-before-write).
- gpio_in reaches GPIO_IN 2 edges after it is stable.
- Timer start: with CTRL.enable written at edge N, the first increment is at edge N+1.
- The match flag and timer_irq rise after the edge where CNT==CMP was sampled. timer_irq is registered-derived and never glitches on addr.
- W1C of STAT.match at edge M drops timer_irq after edge M, unless a new match occurs at edge M.
- No handshake or back-pressure: every access completes in one cycle.

## Test plan
- Reset and readback: hold rst low, release.
  - Reads of 0x000, 0x100, 0x108, 0x10C, 0x114 return 0.
  - gpio_out=0, timer_irq=0.
  - Assert rst mid-count: CNT reads 0 immediately.
- RAM:
  - Write 0x12345678 to 0x03C; next cycle a read of 0x03C returns 0x12345678, and 0x03D–0x03F alias it.
  - Same-cycle read of 0x03C returns the old value 0.
  - Write to 0x0FC and read 0x000: 0x000 unchanged.
- GPIO:
  - Write 0x0001ABCD to 0x100: gpio_out=0xABCD and a read returns 0x0000ABCD.
  - Drive gpio_in=0x5A5A: a read of 0x104 returns 0x00005A5A on the 2nd cycle after, and the old value before that.
- Timer auto-reload:
  - Write CMP=3, then CTRL=0x7: CNT sequence 0,1,2,3,0,1…
  - STAT.match and timer_irq rise after the edge with CNT=3.
  - Write STAT=0x1 with no coincident match: irq drops next cycle.
  - Repeat the W1C on the match edge: flag stays 1.
- Timer overrides and wrap:
  - While counting, write CNT=10: the next read returns 10, not 11.
  - CTRL=0x1, CMP=0, CNT=0xFFFFFFFE: match occurs after the count wraps to 0 and reaches CMP, and the count continues to 1.
- Unmapped access:
  - Write 0xFFFFFFFF to 0x200 and to 0x118: STAT reads 0x2, all other registers are unchanged, and a read of 0x200 returns 0.
  - Write STAT=0x2: STAT reads 0.
